// File: rtl/window_scheduler_if.sv
// Control/status bundle between the window scheduler and its host/datapath.
interface window_scheduler_if;
  logic        start;
  logic        stop;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [12:0] cfg_data;
  logic [3:0]  cfg_len;
  logic [12:0] W;
  logic        dp_reset;
  logic        dp_load;
  logic        dp_en;
  logic        latch;
  logic [6:0]  A_val;
  logic [6:0]  B_val;
  logic        res_valid;
  logic [6:0]  res_A;
  logic [6:0]  res_B;
  logic [2:0]  res_idx;
  logic        res_timeout;
  logic        busy;
  logic        done;

  modport slave (
    input  start, stop, cfg_we, cfg_addr, cfg_data, cfg_len, latch, A_val, B_val,
    output W, dp_reset, dp_load, dp_en, res_valid, res_A, res_B, res_idx,
           res_timeout, busy, done
  );

  modport master (
    output start, stop, cfg_we, cfg_addr, cfg_data, cfg_len, latch, A_val, B_val,
    input  W, dp_reset, dp_load, dp_en, res_valid, res_A, res_B, res_idx,
           res_timeout, busy, done
  );
endinterface

// File: rtl/window_scheduler.sv
// Steps a switch datapath through a table of windows: load, run until a latch
// edge or timeout, capture the counts, then advance or finish.
module window_scheduler #(
  parameter int N_ENTRIES   = 8,
  parameter int LOAD_CYCLES = 3,
  parameter int TIMEOUT     = 1000
) (
  input logic              clk,
  input logic              reset,
  window_scheduler_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LOAD_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAPTURE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [12:0]   tbl_q [N_ENTRIES];
  logic [12:0]   tbl_d [N_ENTRIES];
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    len_q, len_d;
  logic [LW-1:0] ld_cnt_q, ld_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          hist_q, hist_d;
  logic          stop_q, stop_d;
  logic [12:0]   w_q, w_d;
  logic          dp_reset_q, dp_reset_d;
  logic          dp_load_q, dp_load_d;
  logic          dp_en_q, dp_en_d;
  logic          res_valid_q, res_valid_d;
  logic [6:0]    res_a_q, res_a_d;
  logic [6:0]    res_b_q, res_b_d;
  logic [2:0]    res_idx_q, res_idx_d;
  logic          res_to_q, res_to_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          latch_edge;

  always_comb begin
    state_d   = state_q;
    tbl_d     = tbl_q;
    idx_d     = idx_q;
    len_d     = len_q;
    ld_cnt_d  = ld_cnt_q;
    timer_d   = timer_q;
    hist_d    = bus.latch;
    stop_d    = stop_q;
    w_d       = w_q;
    res_a_d   = res_a_q;
    res_b_d   = res_b_q;
    res_idx_d = res_idx_q;
    res_to_d  = res_to_q;

    latch_edge = bus.latch & ~hist_q;

    if (!busy_q && bus.cfg_we && (int'(bus.cfg_addr) < N_ENTRIES))
      tbl_d[bus.cfg_addr] = bus.cfg_data;

    if (bus.stop && (state_q inside {S_LOAD, S_RUN, S_CAPTURE}))
      stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (bus.start && (bus.cfg_len != '0) && (int'(bus.cfg_len) <= N_ENTRIES)) begin
          state_d  = S_LOAD;
          idx_d    = '0;
          len_d    = bus.cfg_len;
          ld_cnt_d = '0;
        end
      end
      S_LOAD: begin
        // History pinned high so a latch already asserted at RUN entry is not an edge.
        hist_d = 1'b1;
        if (ld_cnt_q == LW'(LOAD_CYCLES - 1)) begin
          state_d = S_RUN;
          timer_d = '0;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (latch_edge) begin
          state_d   = S_CAPTURE;
          res_a_d   = bus.A_val;
          res_b_d   = bus.B_val;
          res_to_d  = 1'b0;
          res_idx_d = idx_q;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d   = S_CAPTURE;
          res_a_d   = '0;
          res_b_d   = '0;
          res_to_d  = 1'b1;
          res_idx_d = idx_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        if (stop_q || bus.stop || ({1'b0, idx_q} == (len_q - 4'd1))) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_LOAD;
          idx_d    = idx_q + 3'd1;
          ld_cnt_d = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stop_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    if (state_d == S_LOAD)
      w_d = tbl_q[idx_d];
    dp_reset_d  = (state_d inside {S_IDLE, S_LOAD, S_DONE});
    dp_load_d   = (state_d == S_LOAD);
    dp_en_d     = (state_d == S_RUN);
    res_valid_d = (state_d == S_CAPTURE);
    busy_d      = (state_d inside {S_LOAD, S_RUN, S_CAPTURE});
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    tbl_q <= tbl_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      ld_cnt_q    <= '0;
      timer_q     <= '0;
      hist_q      <= 1'b1;
      stop_q      <= 1'b0;
      w_q         <= '0;
      dp_reset_q  <= 1'b1;
      dp_load_q   <= 1'b0;
      dp_en_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      res_idx_q   <= '0;
      res_to_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      ld_cnt_q    <= ld_cnt_d;
      timer_q     <= timer_d;
      hist_q      <= hist_d;
      stop_q      <= stop_d;
      w_q         <= w_d;
      dp_reset_q  <= dp_reset_d;
      dp_load_q   <= dp_load_d;
      dp_en_q     <= dp_en_d;
      res_valid_q <= res_valid_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
      res_idx_q   <= res_idx_d;
      res_to_q    <= res_to_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.W           = w_q;
  assign bus.dp_reset    = dp_reset_q;
  assign bus.dp_load     = dp_load_q;
  assign bus.dp_en       = dp_en_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_A       = res_a_q;
  assign bus.res_B       = res_b_q;
  assign bus.res_idx     = res_idx_q;
  assign bus.res_timeout = res_to_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_window_scheduler.sv
// Directed bench for window_scheduler: multi-window runs, timeout, latch
// pre-high, early stop, mid-run reset and ignored config/start.
module tb_window_scheduler;

  localparam int N_ENTRIES   = 8;
  localparam int LOAD_CYCLES = 3;
  localparam int TIMEOUT     = 1000;

  logic clk;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  window_scheduler_if bus ();

  window_scheduler #(
    .N_ENTRIES  (N_ENTRIES),
    .LOAD_CYCLES(LOAD_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered while observing the first LOAD cycle; returns while observing CAPTURE.
  task automatic run_window(input logic [12:0] exp_w, input int edge_at,
                            input logic [6:0] a, input logic [6:0] b,
                            input logic [2:0] exp_idx, input bit pre_high,
                            input int stop_at);
    int n_run;
    n_run = (edge_at < 0) ? TIMEOUT - 1 : edge_at;
    bus.latch = pre_high;
    for (int i = 0; i < LOAD_CYCLES; i++) begin
      chk("load_ctl", {bus.dp_load, bus.dp_reset, bus.dp_en, bus.busy, bus.res_valid}, 5'b11010);
      chk("load_w", bus.W, exp_w);
      tick();
    end
    for (int k = 0; k < n_run; k++) begin
      chk("run_ctl", {bus.dp_load, bus.dp_reset, bus.dp_en, bus.busy, bus.res_valid}, 5'b00110);
      bus.latch = pre_high && (k == 0);
      bus.stop  = (k == stop_at);
      bus.A_val = 7'h7f;
      bus.B_val = 7'h7e;
      tick();
    end
    chk("run_last", {bus.dp_load, bus.dp_reset, bus.dp_en, bus.busy, bus.res_valid}, 5'b00110);
    chk("run_w", bus.W, exp_w);
    bus.stop = 1'b0;
    if (edge_at >= 0) begin
      bus.latch = 1'b1;
      bus.A_val = a;
      bus.B_val = b;
    end else begin
      bus.latch = 1'b0;
    end
    tick();
    chk("cap_ctl", {bus.res_valid, bus.dp_en, bus.dp_reset, bus.dp_load, bus.busy}, 5'b10001);
    chk("cap_a", bus.res_A, (edge_at >= 0) ? a : 7'd0);
    chk("cap_b", bus.res_B, (edge_at >= 0) ? b : 7'd0);
    chk("cap_idx", bus.res_idx, exp_idx);
    chk("cap_timeout", bus.res_timeout, (edge_at < 0) ? 1'b1 : 1'b0);
    bus.latch = 1'b0;
  endtask

  task automatic chk_done(input logic [12:0] exp_w);
    chk("done_ctl", {bus.done, bus.busy, bus.dp_reset, bus.dp_load, bus.dp_en, bus.res_valid}, 6'b101000);
    chk("done_w", bus.W, exp_w);
    tick();
    chk("idle_ctl", {bus.done, bus.busy, bus.dp_reset, bus.dp_load, bus.dp_en}, 5'b00100);
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.cfg_len  = '0;
    bus.latch    = 1'b0;
    bus.A_val    = '0;
    bus.B_val    = '0;
    tick();
    tick();
    chk("rst_ctl", {bus.dp_reset, bus.dp_load, bus.dp_en, bus.res_valid, bus.busy, bus.done}, 6'b100000);
    chk("rst_w", bus.W, 13'd0);
    chk("rst_res", {bus.res_A, bus.res_B, bus.res_idx, bus.res_timeout}, 18'd0);
    reset = 1'b0;

    bus.cfg_we = 1'b1;
    bus.cfg_addr = 3'd0; bus.cfg_data = 13'd2;    tick();
    bus.cfg_addr = 3'd1; bus.cfg_data = 13'd6401; tick();
    bus.cfg_addr = 3'd2; bus.cfg_data = 13'd100;  tick();
    bus.cfg_addr = 3'd3; bus.cfg_data = 13'd200;  tick();
    bus.cfg_we = 1'b0;

    // Two windows with latch edges at RUN cycle 20.
    bus.cfg_len = 4'd2; bus.start = 1'b1; tick(); bus.start = 1'b0;
    run_window(13'd2, 20, 7'd5, 7'd9, 3'd0, 1'b0, -1);
    tick();
    run_window(13'd6401, 20, 7'd17, 7'd3, 3'd1, 1'b0, -1);
    tick();
    chk("hold_a", bus.res_A, 7'd17);
    chk_done(13'd6401);

    // Single window timing out.
    bus.cfg_len = 4'd1; bus.start = 1'b1; tick(); bus.start = 1'b0;
    run_window(13'd2, -1, 7'd0, 7'd0, 3'd0, 1'b0, -1);
    tick();
    chk_done(13'd2);

    // Latch already high through LOAD; only the later rise at cycle 10 counts.
    bus.latch = 1'b1; tick(); tick();
    bus.cfg_len = 4'd1; bus.start = 1'b1; tick(); bus.start = 1'b0;
    run_window(13'd2, 10, 7'd33, 7'd44, 3'd0, 1'b1, -1);
    tick();
    chk_done(13'd2);

    // Stop during window 1 ends the sequence after its capture.
    bus.cfg_len = 4'd4; bus.start = 1'b1; tick(); bus.start = 1'b0;
    run_window(13'd2, 5, 7'd1, 7'd2, 3'd0, 1'b0, -1);
    tick();
    run_window(13'd6401, 8, 7'd3, 7'd4, 3'd1, 1'b0, 3);
    tick();
    chk_done(13'd6401);
    tick();
    chk("post_stop_idle", {bus.busy, bus.dp_load, bus.dp_en}, 3'b000);

    // Reset in the middle of RUN.
    bus.cfg_len = 4'd2; bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int i = 0; i < LOAD_CYCLES + 4; i++) tick();
    chk("pre_rst_run", bus.dp_en, 1'b1);
    reset = 1'b1;
    #1;
    chk("arst_ctl", {bus.dp_reset, bus.dp_load, bus.dp_en, bus.res_valid, bus.busy, bus.done}, 6'b100000);
    chk("arst_w", bus.W, 13'd0);
    chk("arst_res", {bus.res_A, bus.res_B, bus.res_idx, bus.res_timeout}, 18'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold", {bus.done, bus.res_valid, bus.busy}, 3'b000);
    end
    reset = 1'b0;
    tick();

    // Out-of-range lengths are ignored.
    bus.cfg_len = 4'd0; bus.start = 1'b1; tick();
    chk("len0_ignored", {bus.busy, bus.dp_load, bus.dp_reset}, 3'b001);
    bus.cfg_len = 4'd9; tick();
    chk("len9_ignored", {bus.busy, bus.dp_load, bus.dp_reset}, 3'b001);
    bus.start = 1'b0;

    // Table writes while busy are dropped.
    bus.cfg_len = 4'd1; bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 13'd1234;
    run_window(13'd2, 3, 7'd7, 7'd8, 3'd0, 1'b0, -1);
    bus.cfg_we = 1'b0;
    tick();
    chk_done(13'd2);

    // Table survives reset and busy writes.
    bus.cfg_len = 4'd2; bus.start = 1'b1; tick(); bus.start = 1'b0;
    run_window(13'd2, 2, 7'd11, 7'd12, 3'd0, 1'b0, -1);
    tick();
    run_window(13'd6401, 4, 7'd13, 7'd14, 3'd1, 1'b0, -1);
    tick();
    chk_done(13'd6401);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/window_scheduler.md
WINDOW_SCHEDULER -- requirements
Module: window_scheduler

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 8, window-table depth.
REQ-002 SHALL have parameter LOAD_CYCLES, default 3, cycles dp_reset/dp_load are held per window.
REQ-003 SHALL have parameter TIMEOUT, default 1000, maximum RUN cycles per window before forced capture.
REQ-004 SHALL have port clk  in  1  core clock; the only clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  begin a sequence, sampled in IDLE only.
REQ-007 SHALL have port stop  in  1  request early end of the sequence.
REQ-008 SHALL have ports cfg_we (in, 1), cfg_addr (in, 3), cfg_data (in, 13): table write port.
REQ-009 SHALL have port cfg_len  in  4  number of windows per sequence, 1..N_ENTRIES.
REQ-010 SHALL have ports W (out, 13), dp_reset (out, 1), dp_load (out, 1), dp_en (out, 1): switch-datapath controls.
REQ-011 SHALL have ports latch (in, 1), A_val (in, 7), B_val (in, 7): datapath status and counts, synchronous to clk.
REQ-012 SHALL have ports res_valid (out, 1), res_A (out, 7), res_B (out, 7), res_idx (out, 3), res_timeout (out, 1), busy (out, 1), done (out, 1).

Function
REQ-013 SHALL write cfg_data to table[cfg_addr] on a clk edge with cfg_we=1 only while busy=0; writes while busy=1 SHALL be ignored.
REQ-014 SHALL implement states IDLE, LOAD, RUN, CAPTURE, DONE.
REQ-015 IDLE: dp_reset=1, dp_load=0, dp_en=0; start=1 with 1<=cfg_len<=N_ENTRIES -> LOAD, idx=0, len latched; start with any other cfg_len SHALL be ignored.
REQ-016 LOAD: W=table[idx], dp_reset=1, dp_load=1, dp_en=0 for exactly LOAD_CYCLES cycles, then RUN.
REQ-017 RUN: dp_reset=0, dp_load=0, dp_en=1, W held; run timer counts from 0 each cycle.
REQ-018 RUN SHALL exit to CAPTURE on the first latch rising edge (latch=1 with previous-cycle latch=0); the edge detector history SHALL be forced to 1 during LOAD, so a latch already high on RUN entry does not trigger.
REQ-019 On the edge cycle, A_val and B_val SHALL be registered; CAPTURE presents them.
REQ-020 If the timer reaches TIMEOUT-1 with no edge -> CAPTURE with res_timeout=1, res_A=res_B=0; a simultaneous edge takes priority (res_timeout=0).
REQ-021 CAPTURE (one cycle): res_valid=1, res_idx=idx, dp_en=0, dp_reset=0; res_A/res_B/res_idx/res_timeout SHALL hold until the next CAPTURE.
REQ-022 After CAPTURE: stop_pending=1 or idx=len-1 -> DONE; otherwise idx+1 -> LOAD.
REQ-023 stop=1 in LOAD, RUN or CAPTURE SHALL set sticky stop_pending, cleared on entry to IDLE; stop in IDLE SHALL be ignored; the current window always completes.
REQ-024 DONE (one cycle): done=1, dp_reset=1, then IDLE.
REQ-025 busy SHALL be 1 in LOAD, RUN and CAPTURE, 0 in IDLE and DONE.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 W SHALL keep its last value in IDLE/DONE.

Reset
REQ-028 reset=1 SHALL immediately force IDLE, dp_reset=1, dp_load=0, dp_en=0, W=0, res_valid=0, res_A=res_B=0, res_idx=0, res_timeout=0, busy=0, done=0, stop_pending=0, timer=0, latch history=1.
REQ-029 Table contents SHALL NOT be cleared by reset.
REQ-030 Reset mid-sequence SHALL abort without res_valid or done pulses.

Verification
REQ-031 Table {2, 6401}, cfg_len=2, start; latch edge 20 cycles into each RUN with A_val=5/B_val=9, then A_val=17/B_val=3 -> W=2 then 6401, each LOAD 3 cycles, res_valid twice with (5,9,idx0) and (17,3,idx1), done one cycle after the second CAPTURE.
REQ-032 cfg_len=1, latch held low -> CAPTURE exactly TIMEOUT cycles after RUN entry, res_timeout=1, res_A=res_B=0, done pulse.
REQ-033 latch held high through LOAD and RUN entry, falls, then rises at RUN cycle 10 -> capture on cycle 10 only.
REQ-034 cfg_len=4, stop pulsed during window 1 RUN -> window 1 captured, no LOAD of window 2, done, busy=0.
REQ-035 reset asserted mid-RUN -> outputs at reset values within the same cycle, no done; a subsequent start works with the table intact.
REQ-036 cfg_we during busy, and start with cfg_len=0 or 9 in IDLE -> table unchanged, no state change.
